// File: rtl/mem_pkg.sv
// Shared types for the RAM arbiter: access encodings, arbiter states and the latched command.
// The access-size helper is used by the range check.
package mem_pkg;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } mem_ctrl_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  // ctrl is kept as raw bits so illegal encodings survive latching and can be flagged.
  typedef struct packed {
    logic        write;
    logic [2:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] wData;
  } mem_cmd_t;

  function automatic logic [2:0] access_size(input mem_ctrl_t ctrl);
    case (ctrl)
      LB, LBU: return 3'd1;
      LH, LHU: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone request wins; on a tie the port not served last wins.
// Purely combinational; the caller owns the last-grant register.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = i_last_grant ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one byte-addressed RAM between a fetch port (p0) and a load/store port (p1),
// validating each command before it reaches the RAM. Optional macro: ALIGN_CHECK_EN.
//
// state  | meaning
// IDLE   | arbitrate, accept one command, latch and validate it
// ACCESS | drive the RAM for one cycle, capture read data
// RESP   | hold the response until the owner consumes it
module ram_arbiter
  import mem_pkg::*;
#(
  parameter int MEM_BYTES = 1024
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic        p0Req,
  output logic        p0Ready,
  input  logic        p0Write,
  input  logic [2:0]  p0Ctrl,
  input  logic [31:0] p0Addr,
  input  logic [31:0] p0WData,
  output logic        p0RspValid,
  input  logic        p0RspReady,
  output logic [31:0] p0RspData,
  output logic        p0RspErr,
  input  logic        p1Req,
  output logic        p1Ready,
  input  logic        p1Write,
  input  logic [2:0]  p1Ctrl,
  input  logic [31:0] p1Addr,
  input  logic [31:0] p1WData,
  output logic        p1RspValid,
  input  logic        p1RspReady,
  output logic [31:0] p1RspData,
  output logic        p1RspErr,
  output logic        ramWrite,
  output logic [2:0]  ramCtrl,
  output logic [31:0] ramAddr,
  output logic [31:0] ramWData,
  input  logic [31:0] ramRData
);

  arb_state_t  r_state;
  arb_state_t  w_state_nxt;
  mem_cmd_t    r_cmd;
  mem_cmd_t    w_sel_cmd;
  logic        r_err;
  logic        r_owner;
  logic        r_last_grant;
  logic [31:0] r_rsp_data;

  logic [1:0]  w_req;
  logic [1:0]  w_grant;
  logic        w_grant_en;
  logic        w_hs;
  logic        w_hs_owner;
  logic        w_rsp_en;
  logic        w_owner_rsp_ready;

  logic [2:0]  w_size;
  logic [32:0] w_end;
  logic        w_bad_ctrl;
  logic        w_bad_write;
  logic        w_bad_range;
  logic        w_misalign;
  logic        w_cmd_err;

  assign w_req = {p1Req, p0Req};

  rr_arb2 u_rr_arb2 (
    .i_req        (w_req),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  // Grants are only offered in IDLE and never while reset is held.
  assign w_grant_en        = (r_state == IDLE) && nReset;
  assign w_hs              = w_grant_en && (w_grant != 2'b00);
  assign w_hs_owner        = w_grant[1];
  assign w_rsp_en          = (r_state == RESP) && nReset;
  assign w_owner_rsp_ready = r_owner ? p1RspReady : p0RspReady;

  always_comb begin
    if (w_grant[1]) begin
      w_sel_cmd.write = p1Write;
      w_sel_cmd.ctrl  = p1Ctrl;
      w_sel_cmd.addr  = p1Addr;
      w_sel_cmd.wData = p1WData;
    end else begin
      w_sel_cmd.write = p0Write;
      w_sel_cmd.ctrl  = p0Ctrl;
      w_sel_cmd.addr  = p0Addr;
      w_sel_cmd.wData = p0WData;
    end
  end

  // The end address is formed 33 bits wide so addresses near 2^32 cannot wrap into range.
  always_comb begin
    w_size      = access_size(mem_ctrl_t'(w_sel_cmd.ctrl));
    w_end       = {1'b0, w_sel_cmd.addr} + {30'd0, w_size};
    w_bad_ctrl  = (w_sel_cmd.ctrl == 3'b011) || (w_sel_cmd.ctrl[2:1] == 2'b11);
    w_bad_write = w_sel_cmd.write && w_sel_cmd.ctrl[2];
    w_bad_range = (w_end > 33'(MEM_BYTES));
`ifdef ALIGN_CHECK_EN
    w_misalign  = ((w_sel_cmd.ctrl[1:0] == 2'b01) && w_sel_cmd.addr[0]) ||
                  ((w_sel_cmd.ctrl[1:0] == 2'b10) && (w_sel_cmd.addr[1:0] != 2'b00));
`else
    w_misalign  = 1'b0;
`endif
    w_cmd_err   = w_bad_ctrl || w_bad_write || w_bad_range || w_misalign;
  end

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_hs) w_state_nxt = ACCESS;
      ACCESS:  w_state_nxt = RESP;
      RESP:    if (w_owner_rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // ramWrite is decoded from state alone, so a store already in ACCESS completes through reset.
  always_comb begin
    p0Ready    = w_grant_en && w_grant[0];
    p1Ready    = w_grant_en && w_grant[1];
    ramWrite   = (r_state == ACCESS) && r_cmd.write && !r_err;
    ramCtrl    = r_cmd.ctrl;
    ramAddr    = r_cmd.addr;
    ramWData   = r_cmd.wData;
    p0RspValid = w_rsp_en && !r_owner;
    p1RspValid = w_rsp_en && r_owner;
    p0RspErr   = w_rsp_en && !r_owner && r_err;
    p1RspErr   = w_rsp_en && r_owner && r_err;
    p0RspData  = (w_rsp_en && !r_owner) ? r_rsp_data : 32'd0;
    p1RspData  = (w_rsp_en && r_owner) ? r_rsp_data : 32'd0;
  end

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      r_cmd        <= '0;
      r_err        <= 1'b0;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_rsp_data   <= 32'd0;
    end else begin
      if (w_hs) begin
        r_cmd        <= w_sel_cmd;
        r_err        <= w_cmd_err;
        r_owner      <= w_hs_owner;
        r_last_grant <= w_hs_owner;
      end
      if (r_state == ACCESS) begin
        r_rsp_data <= (!r_cmd.write && !r_err) ? ramRData : 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: table of single accesses checked through a response scoreboard,
// plus hand sequences for arbitration order, backpressure, latency and mid-operation reset.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        nReset;
  logic        p0Req, p0Ready, p0Write, p0RspValid, p0RspReady, p0RspErr;
  logic [2:0]  p0Ctrl;
  logic [31:0] p0Addr, p0WData, p0RspData;
  logic        p1Req, p1Ready, p1Write, p1RspValid, p1RspReady, p1RspErr;
  logic [2:0]  p1Ctrl;
  logic [31:0] p1Addr, p1WData, p1RspData;
  logic        ramWrite;
  logic [2:0]  ramCtrl;
  logic [31:0] ramAddr, ramWData, ramRData;

  always #5 clk = ~clk;

  ram_arbiter #(.MEM_BYTES(1024)) dut (
    .Clock(clk), .nReset(nReset),
    .p0Req(p0Req), .p0Ready(p0Ready), .p0Write(p0Write), .p0Ctrl(p0Ctrl), .p0Addr(p0Addr),
    .p0WData(p0WData), .p0RspValid(p0RspValid), .p0RspReady(p0RspReady),
    .p0RspData(p0RspData), .p0RspErr(p0RspErr),
    .p1Req(p1Req), .p1Ready(p1Ready), .p1Write(p1Write), .p1Ctrl(p1Ctrl), .p1Addr(p1Addr),
    .p1WData(p1WData), .p1RspValid(p1RspValid), .p1RspReady(p1RspReady),
    .p1RspData(p1RspData), .p1RspErr(p1RspErr),
    .ramWrite(ramWrite), .ramCtrl(ramCtrl), .ramAddr(ramAddr), .ramWData(ramWData),
    .ramRData(ramRData)
  );

  // RAM model: little-endian, does its own byte-lane assembly, combinational read.
  logic [7:0] mem [0:1023];
  logic [9:0] ra0, ra1, ra2, ra3;
  logic [7:0] rb0, rb1, rb2, rb3;
  assign ra0 = ramAddr[9:0];
  assign ra1 = ra0 + 10'd1;
  assign ra2 = ra0 + 10'd2;
  assign ra3 = ra0 + 10'd3;
  assign rb0 = mem[ra0];
  assign rb1 = mem[ra1];
  assign rb2 = mem[ra2];
  assign rb3 = mem[ra3];

  always_comb begin
    case (ramCtrl)
      3'b000:  ramRData = {{24{rb0[7]}}, rb0};
      3'b001:  ramRData = {{16{rb1[7]}}, rb1, rb0};
      3'b100:  ramRData = {24'd0, rb0};
      3'b101:  ramRData = {16'd0, rb1, rb0};
      default: ramRData = {rb3, rb2, rb1, rb0};
    endcase
  end

  initial for (int i = 0; i < 1024; i++) mem[i] = 8'h00;

  always @(posedge clk) begin
    if (ramWrite) begin
      mem[ra0] <= ramWData[7:0];
      if (ramCtrl[1:0] != 2'b00) mem[ra1] <= ramWData[15:8];
      if (ramCtrl[1:0] == 2'b10) begin
        mem[ra2] <= ramWData[23:16];
        mem[ra3] <= ramWData[31:24];
      end
    end
  end

  // Scoreboard: expected responses pushed at issue, actual responses collected on handshake.
  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } rsp_t;

  rsp_t exp0[$], exp1[$], act0[$], act1[$];
  int   grant_q[$];
  int   wr_count = 0;

  always @(negedge clk) begin
    if (p0RspValid && p0RspReady) act0.push_back({p0RspErr, p0RspData});
    if (p1RspValid && p1RspReady) act1.push_back({p1RspErr, p1RspData});
    if (p0Req && p0Ready) grant_q.push_back(0);
    if (p1Req && p1Ready) grant_q.push_back(1);
    if (ramWrite) wr_count++;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input int port, input logic w, input logic [2:0] c,
                       input logic [31:0] a, input logic [31:0] d, output bit ok);
    ok = 1'b0;
    if (port == 0) begin
      p0Req = 1'b1; p0Write = w; p0Ctrl = c; p0Addr = a; p0WData = d;
    end else begin
      p1Req = 1'b1; p1Write = w; p1Ctrl = c; p1Addr = a; p1WData = d;
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((port == 0 && p0Ready) || (port == 1 && p1Ready)) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (port == 0) p0Req = 1'b0; else p1Req = 1'b0;
  endtask

  task automatic wait_rsp(input int port, input string nm);
    rsp_t a, e;
    bit   got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if ((port == 0 && act0.size() > 0) || (port == 1 && act1.size() > 0)) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #2;
    end
    if (!got || (port == 0 && exp0.size() == 0) || (port == 1 && exp1.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL %s no response or no expectation (got=%0d)", nm, got);
      return;
    end
    if (port == 0) begin a = act0.pop_front(); e = exp0.pop_front(); end
    else           begin a = act1.pop_front(); e = exp1.pop_front(); end
    chk({nm, ".data"}, a.data, e.data);
    chk({nm, ".err"}, {31'd0, a.err}, {31'd0, e.err});
  endtask

  task automatic push_exp(input int port, input logic [31:0] d, input logic e);
    if (port == 0) exp0.push_back({e, d}); else exp1.push_back({e, d});
  endtask

  task automatic do_reset();
    nReset = 1'b0;
    repeat (2) @(posedge clk);
    #1 nReset = 1'b1;
  endtask

  typedef struct {
    int          port;
    logic        w;
    logic [2:0]  c;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] ed;
    logic        ee;
    string       nm;
  } vec_t;

  vec_t vt[$];

  task automatic add(input int port, input logic w, input logic [2:0] c, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] ed, input logic ee, input string nm);
    vec_t v;
    v.port = port; v.w = w; v.c = c; v.a = a; v.d = d; v.ed = ed; v.ee = ee; v.nm = nm;
    vt.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok, ok_a, ok_b;
    int wr_base, exp_wr, eg[4];
    eg = '{0, 1, 0, 1};

    p0Req = 1'b1; p0Write = 1'b0; p0Ctrl = 3'b010; p0Addr = 32'h10; p0WData = 32'h0;
    p1Req = 1'b1; p1Write = 1'b0; p1Ctrl = 3'b010; p1Addr = 32'h10; p1WData = 32'h0;
    p0RspReady = 1'b1; p1RspReady = 1'b1;
    nReset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.p0Ready", {31'd0, p0Ready}, 32'd0);
    chk("rst.p1Ready", {31'd0, p1Ready}, 32'd0);
    chk("rst.p0RspValid", {31'd0, p0RspValid}, 32'd0);
    chk("rst.p1RspValid", {31'd0, p1RspValid}, 32'd0);
    chk("rst.ramWrite", {31'd0, ramWrite}, 32'd0);
    chk("rst.ramAddr", ramAddr, 32'd0);
    chk("rst.ramCtrl", {29'd0, ramCtrl}, 32'd0);
    @(posedge clk);
    #1 nReset = 1'b1; p0Req = 1'b0; p1Req = 1'b0;

    add(0, 1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        0, "sw_10");
    add(0, 0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 0, "lw_10");
    add(0, 0, 3'b000, 32'h13,  32'h0,        32'hFFFFFFDE, 0, "lb_13");
    add(0, 0, 3'b100, 32'h13,  32'h0,        32'h000000DE, 0, "lbu_13");
    add(1, 0, 3'b001, 32'h12,  32'h0,        32'hFFFFDEAD, 0, "lh_12");
    add(1, 0, 3'b101, 32'h10,  32'h0,        32'h0000BEEF, 0, "lhu_10");
    add(1, 1, 3'b001, 32'h14,  32'hCAFE8001, 32'h0,        0, "sh_14");
    add(1, 0, 3'b010, 32'h14,  32'h0,        32'h00008001, 0, "lw_14");
    add(0, 1, 3'b010, 32'h3FC, 32'h01020304, 32'h0,        0, "sw_3fc");
    add(0, 0, 3'b010, 32'h3FC, 32'h0,        32'h01020304, 0, "lw_3fc");
    add(0, 0, 3'b010, 32'h3FD, 32'h0,        32'h0,        1, "lw_3fd_range");
    add(0, 0, 3'b000, 32'h3FF, 32'h0,        32'h00000001, 0, "lb_3ff_edge");
    add(1, 1, 3'b001, 32'h3FF, 32'hFFFF,     32'h0,        1, "sh_3ff_range");
    add(0, 0, 3'b000, 32'hFFFFFFFF, 32'h0,   32'h0,        1, "lb_wrap");
    add(1, 1, 3'b100, 32'h40,  32'hAA,       32'h0,        1, "sb_ctrl100");
    add(0, 0, 3'b100, 32'h40,  32'h0,        32'h0,        0, "lbu_40");
    add(0, 0, 3'b011, 32'h0,   32'h0,        32'h0,        1, "ctrl011");
    add(1, 1, 3'b111, 32'h0,   32'h55,       32'h0,        1, "ctrl111");
    add(1, 0, 3'b010, 32'h3FC, 32'h0,        32'h01020304, 0, "lw_3fc_again");
`ifdef ALIGN_CHECK_EN
    add(0, 1, 3'b010, 32'h22,  32'h11223344, 32'h0,        1, "sw_22_mis");
    add(0, 0, 3'b001, 32'h21,  32'h0,        32'h0,        1, "lh_21_mis");
    add(0, 0, 3'b010, 32'h20,  32'h0,        32'h0,        0, "lw_20");
    add(0, 0, 3'b010, 32'h24,  32'h0,        32'h0,        0, "lw_24");
`else
    add(0, 1, 3'b010, 32'h22,  32'h11223344, 32'h0,        0, "sw_22");
    add(0, 0, 3'b001, 32'h21,  32'h0,        32'h00004400, 0, "lh_21");
    add(0, 0, 3'b010, 32'h20,  32'h0,        32'h33440000, 0, "lw_20");
    add(0, 0, 3'b010, 32'h24,  32'h0,        32'h00001122, 0, "lw_24");
`endif

    wr_base = wr_count;
    exp_wr  = 0;
    foreach (vt[i]) begin
      push_exp(vt[i].port, vt[i].ed, vt[i].ee);
      drive(vt[i].port, vt[i].w, vt[i].c, vt[i].a, vt[i].d, ok);
      chk({vt[i].nm, ".grant"}, {31'd0, ok}, 32'd1);
      wait_rsp(vt[i].port, vt[i].nm);
      if (vt[i].w && !vt[i].ee) exp_wr++;
    end
    chk("table.writes", wr_count - wr_base, exp_wr);

    // Latency: handshake t, RAM access t+1, response t+2.
    push_exp(0, 32'hDEADBEEF, 0);
    p0Req = 1'b1; p0Write = 1'b0; p0Ctrl = 3'b010; p0Addr = 32'h10;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (p0Ready) begin ok = 1'b1; break; end
    end
    chk("lat.grant", {31'd0, ok}, 32'd1);
    @(posedge clk);
    #1 p0Req = 1'b0;
    @(negedge clk);
    chk("lat.ramAddr", ramAddr, 32'h10);
    chk("lat.ramCtrl", {29'd0, ramCtrl}, 32'd2);
    chk("lat.valid_t1", {31'd0, p0RspValid}, 32'd0);
    @(negedge clk);
    chk("lat.valid_t2", {31'd0, p0RspValid}, 32'd1);
    wait_rsp(0, "lat");

    // Tie after reset: p0 first, then strict alternation while both stay asserted.
    do_reset();
    grant_q.delete();
    fork
      begin
        ok_a = 1'b1;
        for (int k = 0; k < 2; k++) begin
          bit o;
          push_exp(0, 32'hDEADBEEF, 0);
          drive(0, 1'b0, 3'b010, 32'h10, 32'h0, o);
          ok_a &= o;
        end
      end
      begin
        ok_b = 1'b1;
        for (int k = 0; k < 2; k++) begin
          bit o;
          push_exp(1, 32'h00008001, 0);
          drive(1, 1'b0, 3'b010, 32'h14, 32'h0, o);
          ok_b &= o;
        end
      end
    join
    chk("rr.p0_done", {31'd0, ok_a}, 32'd1);
    chk("rr.p1_done", {31'd0, ok_b}, 32'd1);
    chk("rr.count", grant_q.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < grant_q.size()) chk($sformatf("rr.order%0d", k), grant_q[k], eg[k]);
    end
    for (int k = 0; k < 2; k++) begin
      wait_rsp(0, "rr.p0");
      wait_rsp(1, "rr.p1");
    end

    // Backpressure on p1 with p0 waiting.
    p1RspReady = 1'b0;
    push_exp(1, 32'h01020304, 0);
    drive(1, 1'b0, 3'b010, 32'h3FC, 32'h0, ok);
    chk("bp.p1_grant", {31'd0, ok}, 32'd1);
    p0Req = 1'b1; p0Write = 1'b0; p0Ctrl = 3'b010; p0Addr = 32'h10;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (p1RspValid) begin ok = 1'b1; break; end
    end
    chk("bp.valid_seen", {31'd0, ok}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp.valid_hold", {31'd0, p1RspValid}, 32'd1);
      chk("bp.data_hold", p1RspData, 32'h01020304);
      chk("bp.p0_blocked", {31'd0, p0Ready}, 32'd0);
    end
    @(posedge clk);
    #1 p1RspReady = 1'b1;
    @(negedge clk);
    chk("bp.p0_not_yet", {31'd0, p0Ready}, 32'd0);
    @(negedge clk);
    chk("bp.p0_granted", {31'd0, p0Ready}, 32'd1);
    push_exp(0, 32'hDEADBEEF, 0);
    @(posedge clk);
    #1 p0Req = 1'b0;
    wait_rsp(1, "bp.p1");
    wait_rsp(0, "bp.p0");

    // Reset while a response is pending: response dropped, tie goes back to p0.
    p0RspReady = 1'b0;
    drive(0, 1'b0, 3'b010, 32'h10, 32'h0, ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (p0RspValid) begin ok = 1'b1; break; end
    end
    chk("rr_rst.in_resp", {31'd0, ok}, 32'd1);
    @(posedge clk);
    #1 nReset = 1'b0;
    @(posedge clk);
    #1;
    chk("rr_rst.valid_drop", {31'd0, p0RspValid}, 32'd0);
    p0RspReady = 1'b1;
    nReset = 1'b1;
    p0Req = 1'b1; p0Write = 1'b0; p0Ctrl = 3'b010; p0Addr = 32'h10;
    p1Req = 1'b1; p1Write = 1'b0; p1Ctrl = 3'b010; p1Addr = 32'h14;
    @(negedge clk);
    chk("rr_rst.tie_p0", {31'd0, p0Ready}, 32'd1);
    chk("rr_rst.tie_not_p1", {31'd0, p1Ready}, 32'd0);
    push_exp(0, 32'hDEADBEEF, 0);
    @(posedge clk);
    #1 p0Req = 1'b0; p1Req = 1'b0;
    wait_rsp(0, "rr_rst.p0");

    // Reset while a store is in ACCESS: the write still lands, no response follows.
    p0Req = 1'b1; p0Write = 1'b1; p0Ctrl = 3'b000; p0Addr = 32'h50; p0WData = 32'h77;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (p0Ready) begin ok = 1'b1; break; end
    end
    chk("acc_rst.grant", {31'd0, ok}, 32'd1);
    @(posedge clk);
    #1 p0Req = 1'b0; nReset = 1'b0;
    @(negedge clk);
    chk("acc_rst.ramWrite", {31'd0, ramWrite}, 32'd1);
    @(posedge clk);
    #1 nReset = 1'b1;
    chk("acc_rst.mem", {24'd0, mem[10'h50]}, 32'h77);
    @(negedge clk);
    chk("acc_rst.no_rsp", {31'd0, p0RspValid}, 32'd0);
    push_exp(0, 32'h77, 0);
    drive(0, 1'b0, 3'b100, 32'h50, 32'h0, ok);
    chk("acc_rst.lbu_grant", {31'd0, ok}, 32'd1);
    wait_rsp(0, "acc_rst.lbu_50");

    chk("end.stray_p0", act0.size(), 0);
    chk("end.stray_p1", act1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
